countdown_ctrl: RTL and testbench
=================================

// Module: countdown_ctrl
// PURPOSE
//  Countdown-timer sequencer between the key debouncers and the BCD/7-seg display path.
//  Holds the remaining-seconds value and the FSM (SET/RUN/PAUSE/ALARM).
//  Edits the preset from UP/DOWN keys and decrements once per second from the 1 ms tick.
//  Drives SECS into the binary-to-BCD converter, with digit enables and status flags.
// PARAMETERS
//  MAX_SECS       9999  upper saturation limit of SECS; SW=$clog2(MAX_SECS+1) (14 at default)
//  PRESET         60    preset and SECS value after reset
//  STEP           1     increment/decrement per UP/DOWN pulse
//  TICKS_PER_SEC  1000  TICK pulses per decrement
//  ALARM_TICKS    10000 ALARM duration in TICKs before auto-return to SET
//  BLINK_TICKS    250   half-period of digit blink in TICKs
// PORTS
//  CLK        in   1   system clock; all logic rising-edge
//  CLR        in   1   reset, asynchronous, active-low
//  TICK       in   1   1 ms clock-enable pulse, one CLK wide
//  KEY_START  in   1   debounced start/pause/ack pulse, one CLK wide
//  KEY_RESET  in   1   debounced reset-to-preset pulse, one CLK wide
//  KEY_UP     in   1   debounced increment pulse, one CLK wide; auto-repeat allowed
//  KEY_DOWN   in   1   debounced decrement pulse, one CLK wide; auto-repeat allowed
//  SECS       out  SW  remaining seconds, binary
//  SECS_UPD   out  1   one-CLK pulse, cycle after SECS changes; also cycle after reset release
//  DIGIT_EN   out  4   active-high digit enables for the 4 displayed digits
//  RUNNING    out  1   high in RUN
//  ALARM      out  1   high in ALARM
// BEHAVIOUR
//  Reset: state=SET, SECS=PRESET, preset_reg=PRESET, presc=0, alarm_cnt=0, blink_cnt=0.
//   Output reset values: SECS_UPD=0, DIGIT_EN=4'hF, RUNNING=0, ALARM=0.
//  All outputs registered. A key pulse in cycle n updates state/SECS at edge n+1;
//   SECS_UPD follows at n+2.
//  Key priority in one cycle: KEY_RESET > KEY_START > KEY_UP > KEY_DOWN; lower keys ignored.
//  SET:
//   UP:    SECS = min(SECS+STEP, MAX_SECS).
//   DOWN:  SECS = max(SECS-STEP, 0); no wrap.
//   START: if SECS>0, preset_reg=SECS, presc=0, ->RUN. If SECS==0, START is ignored.
//   RESET: SECS=preset_reg.
//  RUN:
//   Each TICK: presc++. At presc==TICKS_PER_SEC-1 with TICK: presc=0, SECS--.
//   If that decrement reaches 0: ->ALARM, alarm_cnt=0.
//   START: ->PAUSE. presc holds; a coincident TICK/terminal decrement is discarded.
//   RESET: ->SET, SECS=preset_reg. UP/DOWN ignored.
//  PAUSE:
//   TICK is not counted.
//   START: ->RUN, resuming from the held presc.
//   RESET: ->SET, SECS=preset_reg. UP/DOWN ignored.
//  ALARM:
//   SECS=0, ALARM=1. alarm_cnt++ on TICK.
//   At alarm_cnt==ALARM_TICKS-1 with TICK, or on START/RESET: ->SET, SECS=preset_reg, ALARM=0.
//  RUNNING and ALARM are registered decodes of the next state.
//  Counter widths: presc $clog2(TICKS_PER_SEC); alarm_cnt $clog2(ALARM_TICKS).
//  A reset assertion mid-RUN aborts immediately to the reset values; no decrement completes.
// CONFIGURATION
//  COUNTDOWN_CTRL_BLINK_EN defined:
//   In SET and ALARM, DIGIT_EN toggles 4'hF/4'h0 every BLINK_TICKS TICKs.
//   blink_cnt restarts with DIGIT_EN=4'hF on every state entry and on every UP/DOWN pulse.
//   RUN and PAUSE are steady 4'hF.
//  Undefined: DIGIT_EN is constant 4'hF; no blink counter is synthesised.
// STRUCTURE
//  countdown_defs.vh: state encodings SET=2'd0, RUN=2'd1, PAUSE=2'd2, ALARM=2'd3;
//   shared key-priority localparams.
//  Sub-module sec_prescaler: TICK-to-1 s divider with HOLD input and terminal pulse;
//   implements presc. The FSM, SECS arithmetic, alarm and blink counters stay in countdown_ctrl.
// TESTING (TICKS_PER_SEC=10, ALARM_TICKS=20, BLINK_TICKS=4 for sim speed)
//  Reset: CLR low, then high -> SECS=60, state SET, DIGIT_EN=F, SECS_UPD pulse once.
//  Saturation:
//   In SET, 62 DOWN pulses -> SECS=0.
//   START -> stays SET.
//   From SECS=9998, 3 UP pulses -> SECS=9999.
//  Countdown:
//   SECS=3, START, 30 TICKs -> SECS 2,1,0 at TICK 10,20,30.
//   ALARM=1 at TICK 30.
//   20 more TICKs -> SET, SECS=3.
//  Pause: in RUN, START on the terminal TICK -> PAUSE, SECS unchanged, presc held.
//   START then 1 TICK -> decrement.
//  Priority: KEY_RESET+KEY_START in the same RUN cycle -> SET, SECS=preset_reg.
//  Blink (macro on): in SET, DIGIT_EN F,0,F every 4 TICKs.
//   An UP pulse restarts the phase at F.
//   Macro off: DIGIT_EN constant F.

Source files
------------

// File: rtl/countdown_ctrl_pkg.sv
// Shared types for the countdown-timer sequencer: FSM state encoding,
// the one-hot-free key code produced by the key priority resolver, and
// digit-enable constants.
package countdown_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_SET   = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2,
        ST_ALARM = 2'd3
    } state_t;

    // Winning key of one cycle after priority resolution.
    typedef enum logic [2:0] {
        KEY_NONE  = 3'd0,
        KEY_RESET = 3'd1,
        KEY_START = 3'd2,
        KEY_UP    = 3'd3,
        KEY_DOWN  = 3'd4
    } key_t;

    localparam logic [3:0] DIGITS_ON  = 4'hF;
    localparam logic [3:0] DIGITS_OFF = 4'h0;

    // RESET beats START beats UP beats DOWN; losing keys are dropped.
    function automatic key_t resolve_key(input logic k_reset, input logic k_start,
                                         input logic k_up, input logic k_down);
        key_t k;
        k = KEY_NONE;
        if (k_reset)      k = KEY_RESET;
        else if (k_start) k = KEY_START;
        else if (k_up)    k = KEY_UP;
        else if (k_down)  k = KEY_DOWN;
        return k;
    endfunction

endpackage

// File: rtl/countdown_ctrl_sec_prescaler.sv
// TICK-to-one-second divider. Counts TICK pulses while not held and flags
// the tick that completes a second. clear restarts the second from zero.
module countdown_ctrl_sec_prescaler #(
    parameter int TICKS_PER_SEC = 1000,
    localparam int PW = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1
) (
    input  logic clk,
    input  logic clr,
    input  logic tick,
    input  logic hold,
    input  logic clear,
    output logic sec_done
);

    logic [PW-1:0] presc_reg;
    logic          at_last;

    assign at_last  = (presc_reg == PW'(TICKS_PER_SEC - 1));
    // Combinational so the owner can act on the same edge the tick is counted.
    assign sec_done = tick && !hold && at_last;

    // Prescaler count: clear wins, hold freezes, terminal tick wraps to zero.
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            presc_reg <= '0;
        end else if (clear) begin
            presc_reg <= '0;
        end else if (tick && !hold) begin
            presc_reg <= at_last ? '0 : presc_reg + PW'(1);
        end
    end

endmodule

// File: rtl/countdown_ctrl.sv
// Countdown-timer sequencer: SET/RUN/PAUSE/ALARM FSM, remaining-seconds
// register with saturating preset editing, alarm timeout and display flags.
// Optional digit blinking in SET/ALARM is built when COUNTDOWN_CTRL_BLINK_EN
// is defined; otherwise digit_en is constant 4'hF.
module countdown_ctrl
    import countdown_ctrl_pkg::*;
#(
    parameter int MAX_SECS      = 9999,
    parameter int PRESET        = 60,
    parameter int STEP          = 1,
    parameter int TICKS_PER_SEC = 1000,
    parameter int ALARM_TICKS   = 10000,
    parameter int BLINK_TICKS   = 250,
    localparam int SW = $clog2(MAX_SECS + 1)
) (
    input  logic          clk,
    input  logic          clr,
    input  logic          tick,
    input  logic          key_start,
    input  logic          key_reset,
    input  logic          key_up,
    input  logic          key_down,
    output logic [SW-1:0] secs,
    output logic          secs_upd,
    output logic [3:0]    digit_en,
    output logic          running,
    output logic          alarm
);

    localparam int AW = (ALARM_TICKS > 1) ? $clog2(ALARM_TICKS) : 1;

    if (MAX_SECS < 1 || STEP < 1 || TICKS_PER_SEC < 1 || ALARM_TICKS < 1 ||
        BLINK_TICKS < 1 || PRESET < 0 || PRESET > MAX_SECS) begin : g_bad_params
        $error("countdown_ctrl: illegal parameter set");
    end

    state_t        state_reg, state_next;
    logic [SW-1:0] secs_reg, secs_next;
    logic [SW-1:0] preset_reg, preset_next;
    logic [AW-1:0] alarm_cnt_reg, alarm_cnt_next;
    logic          chg_reg, secs_upd_reg, running_reg, alarm_reg;
    logic [SW:0]   secs_inc;
    logic [SW-1:0] secs_up, secs_dn;
    logic          presc_clear, presc_hold, sec_done;
    key_t          key;

    assign key      = resolve_key(key_reset, key_start, key_up, key_down);
    assign secs_inc = {1'b0, secs_reg} + (SW+1)'(STEP);
    assign secs_up  = (secs_inc > (SW+1)'(MAX_SECS)) ? SW'(MAX_SECS) : secs_inc[SW-1:0];
    assign secs_dn  = (secs_reg < SW'(STEP)) ? '0 : secs_reg - SW'(STEP);

    // Prescaler only advances in RUN when no control key overrides the tick.
    assign presc_hold = (state_reg != ST_RUN) || key_start || key_reset;

    countdown_ctrl_sec_prescaler #(
        .TICKS_PER_SEC(TICKS_PER_SEC)
    ) u_presc (
        .clk     (clk),
        .clr     (clr),
        .tick    (tick),
        .hold    (presc_hold),
        .clear   (presc_clear),
        .sec_done(sec_done)
    );

    // Next-state, SECS arithmetic and alarm timeout.
    always_comb begin
        state_next     = state_reg;
        secs_next      = secs_reg;
        preset_next    = preset_reg;
        alarm_cnt_next = alarm_cnt_reg;
        presc_clear    = 1'b0;
        case (state_reg)
            ST_SET: begin
                case (key)
                    KEY_RESET: secs_next = preset_reg;
                    KEY_START: begin
                        if (secs_reg != '0) begin
                            preset_next = secs_reg;
                            presc_clear = 1'b1;
                            state_next  = ST_RUN;
                        end
                    end
                    KEY_UP:    secs_next = secs_up;
                    KEY_DOWN:  secs_next = secs_dn;
                    default:   ;
                endcase
            end
            ST_RUN: begin
                if (key == KEY_RESET) begin
                    state_next = ST_SET;
                    secs_next  = preset_reg;
                end else if (key == KEY_START) begin
                    state_next = ST_PAUSE;
                end else if (sec_done) begin
                    secs_next = secs_reg - SW'(1);
                    if (secs_reg == SW'(1)) begin
                        state_next     = ST_ALARM;
                        alarm_cnt_next = '0;
                    end
                end
            end
            ST_PAUSE: begin
                if (key == KEY_RESET) begin
                    state_next = ST_SET;
                    secs_next  = preset_reg;
                end else if (key == KEY_START) begin
                    state_next = ST_RUN;
                end
            end
            ST_ALARM: begin
                secs_next = '0;
                if (key == KEY_RESET || key == KEY_START ||
                    (tick && alarm_cnt_reg == AW'(ALARM_TICKS - 1))) begin
                    state_next = ST_SET;
                    secs_next  = preset_reg;
                end else if (tick) begin
                    alarm_cnt_next = alarm_cnt_reg + AW'(1);
                end
            end
            default: state_next = ST_SET;
        endcase
    end

    // State, value registers and registered status outputs.
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            state_reg     <= ST_SET;
            secs_reg      <= SW'(PRESET);
            preset_reg    <= SW'(PRESET);
            alarm_cnt_reg <= '0;
            chg_reg       <= 1'b1;   // a fresh reset counts as a SECS load
            secs_upd_reg  <= 1'b0;
            running_reg   <= 1'b0;
            alarm_reg     <= 1'b0;
        end else begin
            state_reg     <= state_next;
            secs_reg      <= secs_next;
            preset_reg    <= preset_next;
            alarm_cnt_reg <= alarm_cnt_next;
            chg_reg       <= (secs_next != secs_reg);
            secs_upd_reg  <= chg_reg;
            running_reg   <= (state_next == ST_RUN);
            alarm_reg     <= (state_next == ST_ALARM);
        end
    end

    assign secs     = secs_reg;
    assign secs_upd = secs_upd_reg;
    assign running  = running_reg;
    assign alarm    = alarm_reg;

`ifdef COUNTDOWN_CTRL_BLINK_EN
    localparam int BW = (BLINK_TICKS > 1) ? $clog2(BLINK_TICKS) : 1;

    logic [BW-1:0] blink_cnt_reg;
    logic [3:0]    digit_en_reg;
    logic          blink_restart, blink_active;

    assign blink_restart = (state_next != state_reg) ||
                           (state_reg == ST_SET && (key == KEY_UP || key == KEY_DOWN));
    assign blink_active  = (state_reg == ST_SET) || (state_reg == ST_ALARM);

    // Blink phase: restart lit on state entry or edit, toggle every BLINK_TICKS ticks.
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            blink_cnt_reg <= '0;
            digit_en_reg  <= DIGITS_ON;
        end else if (blink_restart || !blink_active) begin
            blink_cnt_reg <= '0;
            digit_en_reg  <= DIGITS_ON;
        end else if (tick) begin
            if (blink_cnt_reg == BW'(BLINK_TICKS - 1)) begin
                blink_cnt_reg <= '0;
                digit_en_reg  <= (digit_en_reg == DIGITS_ON) ? DIGITS_OFF : DIGITS_ON;
            end else begin
                blink_cnt_reg <= blink_cnt_reg + BW'(1);
            end
        end
    end

    assign digit_en = digit_en_reg;
`else
    assign digit_en = DIGITS_ON;
`endif

endmodule

// File: tb/tb_countdown_ctrl.sv
// Self-checking bench for countdown_ctrl with shortened timing constants.
// Expected outputs are queued when a cycle's stimulus is driven and popped
// and compared one edge later.
module tb_countdown_ctrl;

    localparam int TPS  = 10;
    localparam int AT   = 20;
    localparam int BT   = 4;
    localparam int MAXS = 9999;
    localparam int PRE  = 60;

`ifdef COUNTDOWN_CTRL_BLINK_EN
    localparam bit BLINK = 1'b1;
`else
    localparam bit BLINK = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        clr = 1'b0;
    logic        tick = 1'b0;
    logic        key_start = 1'b0;
    logic        key_reset = 1'b0;
    logic        key_up = 1'b0;
    logic        key_down = 1'b0;
    logic [13:0] secs;
    logic        secs_upd;
    logic [3:0]  digit_en;
    logic        running;
    logic        alarm;

    int errors = 0;
    int checks = 0;

    typedef struct {
        string      name;
        int         secs;
        logic       running;
        logic       alarm;
        logic [3:0] den;
        bit         chk_den;
    } exp_t;

    typedef struct {
        string name;
        logic  rst, start, up, down, tk;
        int    secs;
        logic  running, alarm;
    } vec_t;

    exp_t sb_q[$];

    countdown_ctrl #(
        .MAX_SECS     (MAXS),
        .PRESET       (PRE),
        .STEP         (1),
        .TICKS_PER_SEC(TPS),
        .ALARM_TICKS  (AT),
        .BLINK_TICKS  (BT)
    ) dut (
        .clk      (clk),
        .clr      (clr),
        .tick     (tick),
        .key_start(key_start),
        .key_reset(key_reset),
        .key_up   (key_up),
        .key_down (key_down),
        .secs     (secs),
        .secs_upd (secs_upd),
        .digit_en (digit_en),
        .running  (running),
        .alarm    (alarm)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic exp_t mk(input string n, input int s, input logic r, input logic a,
                                input logic [3:0] d, input bit cd);
        exp_t e;
        e.name = n; e.secs = s; e.running = r; e.alarm = a; e.den = d; e.chk_den = cd;
        return e;
    endfunction

    // One cycle: drive keys, queue the expectation, compare after the edge.
    task automatic drive(input logic r, input logic s, input logic u, input logic d,
                         input logic t, input exp_t e);
        exp_t got;
        key_reset = r; key_start = s; key_up = u; key_down = d; tick = t;
        sb_q.push_back(e);
        @(posedge clk);
        #1;
        key_reset = 0; key_start = 0; key_up = 0; key_down = 0; tick = 0;
        got = sb_q.pop_front();
        chk({got.name, ".secs"}, int'(secs), got.secs);
        chk({got.name, ".running"}, int'(running), int'(got.running));
        chk({got.name, ".alarm"}, int'(alarm), int'(got.alarm));
        if (got.chk_den) chk({got.name, ".digit_en"}, int'(digit_en), int'(got.den));
        $display("txn %s: secs=%0d running=%0d alarm=%0d digit_en=%h upd=%0d",
                 got.name, secs, running, alarm, digit_en, secs_upd);
    endtask

    // Hold an edit key high for n consecutive cycles (auto-repeat).
    task automatic burst(input logic u, input logic d, input int n);
        key_up = u; key_down = d;
        repeat (n) @(posedge clk);
        #1;
        key_up = 0; key_down = 0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        vec_t tbl[14];
        logic [3:0] dexp;

        tbl[0]  = '{"up1",         0, 0, 1, 0, 0, 61, 0, 0};
        tbl[1]  = '{"up2",         0, 0, 1, 0, 0, 62, 0, 0};
        tbl[2]  = '{"down1",       0, 0, 0, 1, 0, 61, 0, 0};
        tbl[3]  = '{"up_beats_dn", 0, 0, 1, 1, 0, 62, 0, 0};
        tbl[4]  = '{"set_reset",   1, 0, 0, 0, 0, 60, 0, 0};
        tbl[5]  = '{"start_run",   0, 1, 1, 0, 0, 60, 1, 0};
        tbl[6]  = '{"run_up_ign",  0, 0, 1, 0, 0, 60, 1, 0};
        tbl[7]  = '{"run_tick",    0, 0, 0, 0, 1, 60, 1, 0};
        tbl[8]  = '{"pause",       0, 1, 0, 0, 0, 60, 0, 0};
        tbl[9]  = '{"pause_tick",  0, 0, 0, 0, 1, 60, 0, 0};
        tbl[10] = '{"pause_dn",    0, 0, 0, 1, 0, 60, 0, 0};
        tbl[11] = '{"pause_reset", 1, 0, 0, 0, 0, 60, 0, 0};
        tbl[12] = '{"down2",       0, 0, 0, 1, 0, 59, 0, 0};
        tbl[13] = '{"rst_beats_st",1, 1, 0, 0, 0, 60, 0, 0};

        // Reset state and the single post-release SECS_UPD pulse.
        clr = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst.secs", int'(secs), PRE);
        chk("rst.running", int'(running), 0);
        chk("rst.alarm", int'(alarm), 0);
        chk("rst.digit_en", int'(digit_en), 15);
        chk("rst.secs_upd", int'(secs_upd), 0);
        clr = 1'b1;
        @(posedge clk); #1;
        chk("rel.secs_upd", int'(secs_upd), 1);
        @(posedge clk); #1;
        chk("rel.secs_upd_once", int'(secs_upd), 0);

        for (int i = 0; i < 14; i++) begin
            drive(tbl[i].rst, tbl[i].start, tbl[i].up, tbl[i].down, tbl[i].tk,
                  mk(tbl[i].name, tbl[i].secs, tbl[i].running, tbl[i].alarm, 4'hF, 1'b1));
        end

        // Saturation at both ends; START at zero is ignored.
        burst(1'b0, 1'b1, 62);
        chk("sat.zero", int'(secs), 0);
        drive(0, 0, 0, 1, 0, mk("dn_at_zero", 0, 0, 0, 4'hF, 1'b0));
        drive(0, 1, 0, 0, 0, mk("start_at_zero", 0, 0, 0, 4'hF, 1'b0));
        drive(0, 0, 0, 0, 1, mk("still_set", 0, 0, 0, 4'hF, 1'b0));
        burst(1'b1, 1'b0, 9998);
        chk("sat.9998", int'(secs), 9998);
        for (int i = 0; i < 3; i++) drive(0, 0, 1, 0, 0, mk("up_sat", MAXS, 0, 0, 4'hF, 1'b0));

        // Countdown from 3 into ALARM and auto-return to SET.
        drive(1, 0, 0, 0, 0, mk("cd_reset", PRE, 0, 0, 4'hF, 1'b0));
        burst(1'b0, 1'b1, 57);
        chk("cd.preset3", int'(secs), 3);
        drive(0, 1, 0, 0, 0, mk("cd_start", 3, 1, 0, 4'hF, 1'b1));
        for (int k = 1; k <= 30; k++) begin
            drive(0, 0, 0, 0, 1, mk($sformatf("cd_tick%0d", k), 3 - k / TPS, k < 30, k >= 30, 4'hF, 1'b0));
            drive(0, 0, 0, 0, 0, mk($sformatf("cd_idle%0d", k), 3 - k / TPS, k < 30, k >= 30, 4'hF, 1'b0));
            chk($sformatf("cd_upd%0d", k), int'(secs_upd), int'(k % TPS == 0));
        end
        for (int k = 1; k <= AT; k++) begin
            drive(0, 0, 0, 0, 1, mk($sformatf("al_tick%0d", k), (k < AT) ? 0 : 3, 0, k < AT, 4'hF, 1'b0));
        end

        // Pause on the terminal tick discards it; resume then one tick decrements.
        drive(0, 1, 0, 0, 0, mk("p_start", 3, 1, 0, 4'hF, 1'b1));
        for (int k = 1; k < TPS; k++) drive(0, 0, 0, 0, 1, mk("p_tick", 3, 1, 0, 4'hF, 1'b1));
        drive(0, 1, 0, 0, 1, mk("p_pause_term", 3, 0, 0, 4'hF, 1'b1));
        for (int k = 0; k < 3; k++) drive(0, 0, 0, 0, 1, mk("p_held", 3, 0, 0, 4'hF, 1'b1));
        drive(0, 1, 0, 0, 0, mk("p_resume", 3, 1, 0, 4'hF, 1'b1));
        drive(0, 0, 0, 0, 1, mk("p_dec", 2, 1, 0, 4'hF, 1'b1));
        drive(0, 0, 0, 0, 0, mk("p_idle", 2, 1, 0, 4'hF, 1'b1));
        chk("p_upd", int'(secs_upd), 1);

        // RESET beats START in RUN.
        drive(1, 1, 0, 0, 0, mk("prio_run", 3, 0, 0, 4'hF, 1'b1));

        // Blink phase in SET, restarted by an UP pulse.
        for (int k = 1; k <= 12; k++) begin
            dexp = (BLINK && ((k / BT) % 2 == 1)) ? 4'h0 : 4'hF;
            drive(0, 0, 0, 0, 1, mk($sformatf("blink%0d", k), 3, 0, 0, dexp, 1'b1));
        end
        drive(0, 0, 1, 0, 0, mk("blink_up", 4, 0, 0, 4'hF, 1'b1));
        for (int k = 1; k <= BT; k++) begin
            dexp = (BLINK && k >= BT) ? 4'h0 : 4'hF;
            drive(0, 0, 0, 0, 1, mk($sformatf("blink_r%0d", k), 4, 0, 0, dexp, 1'b1));
        end

        // Asynchronous reset in the middle of RUN aborts at once.
        drive(0, 1, 0, 0, 0, mk("ar_start", 4, 1, 0, 4'hF, 1'b1));
        for (int k = 0; k < 5; k++) drive(0, 0, 0, 0, 1, mk("ar_tick", 4, 1, 0, 4'hF, 1'b1));
        #2;
        clr = 1'b0;
        #1;
        chk("ar.secs", int'(secs), PRE);
        chk("ar.running", int'(running), 0);
        chk("ar.alarm", int'(alarm), 0);
        @(posedge clk); #1;
        clr = 1'b1;
        repeat (2) @(posedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
